// File: rtl/uart_rx.sv
// Purpose : 8N1-style UART receiver that turns the UART_RX pad into words on a valid/ready port.
// Latency : word presented one cycle after the mid-stop-bit sample (m_valid rises on that edge).
// Backpres: never stalls the line; a word completing while the 1-entry buffer is held is dropped
//           and flagged on overrun.
//
// Ports
//   SYS_CLK   in   1          system clock, rising edge
//   RESET     in   1          synchronous active-high reset
//   UART_RX   in   1          asynchronous serial input, idle high
//   m_data    out  DATA_BITS  received word, meaningful while m_valid=1
//   m_valid   out  1          word available
//   m_ready   in   1          consumer takes m_data when m_valid && m_ready
//   frame_err out  1          one-cycle pulse: stop bit sampled low
//   overrun   out  1          one-cycle pulse: word completed while buffer full, new word lost

module uart_rx #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int DATA_BITS   = 8,   // 5..9
    parameter int SYNC_STAGES = 2    // >= 2
) (
    input  logic                 SYS_CLK,
    input  logic                 RESET,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    // Bit period in clocks, rounded to nearest; HALF positions the first
    // sample in the middle of the start bit.
    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser. Resets to the idle (high) level so a reset never
    // manufactures a falling edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RX};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame FSM plus the single-entry output buffer.
    // ------------------------------------------------------------------
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [DATA_BITS-1:0]   shift;

    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumer handshake; a completion later in this block may
            // re-assert m_valid in the same cycle.
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= CNT_HALF;
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (rx_s) begin
                        // Line went back high before mid start bit: glitch.
                        state <= ST_IDLE;
                    end else begin
                        cnt   <= CNT_FULL;
                        idx   <= '0;
                        state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shift[idx] <= rx_s;
                        cnt        <= CNT_FULL;
                        if (idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end

                ST_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (rx_s) begin
                        state <= ST_IDLE;
                        // Buffer free, or being drained this same cycle.
                        if (!m_valid || m_ready) begin
                            m_data  <= shift;
                            m_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                        state     <= ST_BREAK;
                    end
                end

                ST_BREAK: begin
                    // Hold off until the line idles so a stuck-low line
                    // does not look like an endless train of start bits.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Purpose : directed bench for uart_rx at DIV=8 / HALF=4 with a frame-level expectation model.
// Latency : model expects a completed word 79 cycles after the start bit is driven.
// Backpres: m_ready is driven per test; overrun behaviour exercised with m_ready held low.

module tb_uart_rx;

    localparam int DIV  = 8;
    // Start drive -> stop-sample edge: 2 sync + 1 detect + HALF + DIV*(8 data + stop).
    localparam int LAT  = 79;

    logic       SYS_CLK;
    logic       RESET;
    logic       UART_RX;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLK_HZ      (800_000),
        .BAUD        (100_000),
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .SYS_CLK   (SYS_CLK),
        .RESET     (RESET),
        .UART_RX   (UART_RX),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit armed = 0;

    typedef struct {
        int         when;
        bit         ferr;
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    logic       exp_valid, exp_ferr, exp_ovr;
    logic [7:0] exp_data;

    logic [7:0] got_d[$];
    int         got_c[$];
    int         n_ferr = 0;
    int         n_ovr  = 0;
    int         n_vcyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Frame-level model: each driven frame schedules one outcome at a known
    // cycle; the buffer rules decide what the outputs must show.
    always @(posedge SYS_CLK) begin
        bit  was_valid;
        ev_t e;
        cyc++;
        if (RESET) begin
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            exp_ferr  = 1'b0;
            exp_ovr   = 1'b0;
            evq.delete();
        end else begin
            was_valid = exp_valid;
            exp_ferr  = 1'b0;
            exp_ovr   = 1'b0;
            if (exp_valid && m_ready) exp_valid = 1'b0;
            while (evq.size() > 0 && evq[0].when == cyc) begin
                e = evq.pop_front();
                if (e.ferr) begin
                    exp_ferr = 1'b1;
                end else if (!was_valid || m_ready) begin
                    exp_data  = e.d;
                    exp_valid = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge SYS_CLK) begin
        if (armed) begin
            chk("m_valid",   m_valid,   exp_valid);
            chk("m_data",    m_data,    exp_data);
            chk("frame_err", frame_err, exp_ferr);
            chk("overrun",   overrun,   exp_ovr);
            if (m_valid === 1'b1) n_vcyc++;
            if (frame_err === 1'b1) n_ferr++;
            if (overrun === 1'b1) n_ovr++;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                got_d.push_back(m_data);
                got_c.push_back(cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge SYS_CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        ev_t        e;
        bits   = {stop_bit, d, 1'b0};
        e.when = cyc + LAT;
        e.ferr = !stop_bit;
        e.d    = d;
        evq.push_back(e);
        for (int i = 0; i < 10; i++) begin
            UART_RX = bits[i];
            repeat (DIV) @(posedge SYS_CLK);
            #1;
        end
        UART_RX = 1'b1;
    endtask

    task automatic clear_log();
        got_d.delete();
        got_c.delete();
        n_ferr = 0;
        n_ovr  = 0;
        n_vcyc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    int s;

    initial begin
        RESET   = 1'b1;
        UART_RX = 1'b1;
        m_ready = 1'b1;
        idle(1);
        armed = 1;
        idle(2);
        chk("rst_m_valid",   m_valid,   1'b0);
        chk("rst_m_data",    m_data,    8'h00);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overrun",   overrun,   1'b0);
        RESET = 1'b0;
        idle(5);

        // 1: single frame, one-cycle m_valid, latency pinned.
        clear_log();
        s = cyc;
        send_frame(8'h55, 1'b1);
        idle(4);
        chk("t1_words", got_d.size(), 1);
        if (got_d.size() > 0) begin
            chk("t1_data", got_d[0], 8'h55);
            chk("t1_lat",  got_c[0] - s, 79);
        end
        chk("t1_vcyc", n_vcyc, 1);
        chk("t1_errs", n_ferr + n_ovr, 0);

        // 2: two-cycle glitch rejected, then a good frame.
        clear_log();
        UART_RX = 1'b0;
        idle(2);
        UART_RX = 1'b1;
        idle(20);
        chk("t2_glitch_words", got_d.size(), 0);
        send_frame(8'hC3, 1'b1);
        idle(4);
        chk("t2_words", got_d.size(), 1);
        if (got_d.size() > 0) chk("t2_data", got_d[0], 8'hC3);
        chk("t2_ferr", n_ferr, 0);

        // 3: bad stop bit, then recovery.
        clear_log();
        send_frame(8'hA3, 1'b0);
        idle(20);
        chk("t3_ferr", n_ferr, 1);
        chk("t3_bad_words", got_d.size(), 0);
        send_frame(8'h3C, 1'b1);
        idle(4);
        chk("t3_words", got_d.size(), 1);
        if (got_d.size() > 0) chk("t3_data", got_d[0], 8'h3C);

        // 4: consumer stalled, second word overruns.
        clear_log();
        m_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(3);
        chk("t4_hold_data",  m_data,  8'h11);
        chk("t4_hold_valid", m_valid, 1'b1);
        chk("t4_ovr",        n_ovr,   1);
        m_ready = 1'b1;
        idle(2);
        chk("t4_drained", m_valid, 1'b0);
        chk("t4_words", got_d.size(), 1);
        if (got_d.size() > 0) chk("t4_data", got_d[0], 8'h11);

        // 5: reset during data bit 4 of 0xF0.
        clear_log();
        fork
            send_frame(8'hF0, 1'b1);
            begin
                idle(42);
                RESET = 1'b1;
                idle(1);
                RESET = 1'b0;
                chk("t5_rst_valid", m_valid, 1'b0);
                chk("t5_rst_data",  m_data,  8'h00);
            end
        join
        idle(10);
        chk("t5_no_word", got_d.size(), 0);
        send_frame(8'h7E, 1'b1);
        idle(4);
        chk("t5_words", got_d.size(), 1);
        if (got_d.size() > 0) chk("t5_data", got_d[0], 8'h7E);

        // 6: back-to-back frames with no idle gap.
        clear_log();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h80, 1'b1);
        idle(4);
        chk("t6_words", got_d.size(), 3);
        if (got_d.size() == 3) begin
            chk("t6_d0", got_d[0], 8'h00);
            chk("t6_d1", got_d[1], 8'hFF);
            chk("t6_d2", got_d[2], 8'h80);
            chk("t6_gap", got_c[2] - got_c[1], 80);
        end
        chk("t6_errs", n_ferr + n_ovr, 0);

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
